// File: rtl/alu_pkg.sv
// Shared types for the alu write-back slice: condition codes,
// flag bit positions and the buffered write-back entry.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'ha,
        COND_LT = 4'hb,
        COND_GT = 4'hc,
        COND_LE = 4'hd,
        COND_AL = 4'he
    } cond_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_ctrl_e;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [REG_W-1:0]  rd;
        logic              we;
        logic              condex;
    } wb_entry_t;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM-style condition evaluation against NZCV.
// Code 4'hF has no dedicated meaning here and behaves like AL.
module cond_check
    import alu_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       condex_o
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flags_i[FLAG_N];
    assign z = flags_i[FLAG_Z];
    assign c = flags_i[FLAG_C];
    assign v = flags_i[FLAG_V];

    always_comb begin
        condex_o = 1'b1;
        unique case (cond_i)
            COND_EQ: condex_o = z;
            COND_NE: condex_o = ~z;
            COND_CS: condex_o = c;
            COND_CC: condex_o = ~c;
            COND_MI: condex_o = n;
            COND_PL: condex_o = ~n;
            COND_VS: condex_o = v;
            COND_VC: condex_o = ~v;
            COND_HI: condex_o = c & ~z;
            COND_LS: condex_o = ~c | z;
            COND_GE: condex_o = (n == v);
            COND_LT: condex_o = (n != v);
            COND_GT: condex_o = ~z & (n == v);
            COND_LE: condex_o = z | (n != v);
            default: condex_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// Post-alu stage: owns the NZCV register, qualifies write-back by
// condition code and feeds the register file via a 2-entry skid buffer.
module alu_writeback_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int RADDR = REG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Result,
    input  logic [3:0]       ALUFlags,
    input  logic [3:0]       Cond,
    input  logic [1:0]       FlagWrite,
    input  logic             RegWrite,
    input  logic [RADDR-1:0] Rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [RADDR-1:0] out_rd,
    output logic             out_we,
    output logic             out_condex,
    output logic [3:0]       Flags
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       rdy_q;
    logic       rdy_d;
    wb_entry_t  head_q;
    wb_entry_t  head_d;
    wb_entry_t  tail_q;
    wb_entry_t  tail_d;
    wb_entry_t  in_entry;
    logic       condex;
    logic       accept;
    logic       pop;

    cond_check u_cond (
        .cond_i   (Cond),
        .flags_i  (flags_q),
        .condex_o (condex)
    );

    // Ready comes from a register so out_ready never reaches in_ready.
    assign in_ready  = rdy_q & ~reset;
    assign accept    = in_valid & in_ready;
    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid & out_ready;

    always_comb begin
        in_entry.result = Result;
        in_entry.rd     = Rd;
        in_entry.we     = RegWrite & condex;
        in_entry.condex = condex;
    end

    always_comb begin
        flags_d = flags_q;
        if (accept && condex) begin
            if (FlagWrite[1]) begin
                flags_d[FLAG_N] = ALUFlags[FLAG_N];
                flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
            end
            if (FlagWrite[0]) begin
                flags_d[FLAG_C] = ALUFlags[FLAG_C];
                flags_d[FLAG_V] = ALUFlags[FLAG_V];
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (count_q)
            2'd0: begin
                if (accept) begin
                    head_d  = in_entry;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (accept && pop) begin
                    head_d = in_entry;
                end else if (accept) begin
                    tail_d  = in_entry;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end
            end
        endcase
        rdy_d = (count_d < 2'd2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
            count_q <= '0;
            rdy_q   <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            flags_q <= flags_d;
            count_q <= count_d;
            rdy_q   <= rdy_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // An empty buffer keeps showing the last head but never writes.
    assign out_result = head_q.result;
    assign out_rd     = head_q.rd;
    assign out_we     = head_q.we & out_valid;
    assign out_condex = head_q.condex;
    assign Flags      = flags_q;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Scoreboard bench for alu_writeback_stage: a flag/condition model
// predicts each accepted op, and pops are compared in order.
module tb_alu_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Result;
    logic [3:0]  ALUFlags;
    logic [3:0]  Cond;
    logic [1:0]  FlagWrite;
    logic        RegWrite;
    logic [3:0]  Rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_rd;
    logic        out_we;
    logic        out_condex;
    logic [3:0]  Flags;

    typedef struct {
        logic [31:0] result;
        logic [3:0]  rd;
        logic        we;
        logic        condex;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [3:0] mflags = 4'h0;
    logic       ce;
    int         n_checks = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    alu_writeback_stage dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Result     (Result),
        .ALUFlags   (ALUFlags),
        .Cond       (Cond),
        .FlagWrite  (FlagWrite),
        .RegWrite   (RegWrite),
        .Rd         (Rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_we     (out_we),
        .out_condex (out_condex),
        .Flags      (Flags)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic cond_ok(input logic [3:0] c,
                                     input logic [3:0] f);
        logic n;
        logic z;
        logic cy;
        logic v;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'ha: return n == v;
            4'hb: return n != v;
            4'hc: return !z && (n == v);
            4'hd: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    // Sample 1ns before each rising edge: what is seen here is what
    // the DUT registers at that edge.
    always @(negedge clk) begin
        #4;
        if (reset) begin
            sb.delete();
            mflags = 4'h0;
        end else begin
            chk("flags", Flags, mflags);
            chk("valid", out_valid, sb.size() != 0);
            if (!out_valid)
                chk("we_empty", out_we, 1'b0);
            if (out_valid && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                chk("result", out_result, e.result);
                chk("rd", out_rd, e.rd);
                chk("we", out_we, e.we);
                chk("condex", out_condex, e.condex);
            end
            if (in_valid && in_ready) begin
                ce = cond_ok(Cond, mflags);
                sb.push_back('{Result, Rd, RegWrite & ce, ce});
                if (ce && FlagWrite[1])
                    mflags[3:2] = ALUFlags[3:2];
                if (ce && FlagWrite[0])
                    mflags[1:0] = ALUFlags[1:0];
            end
        end
    end

    task automatic drive(input logic [31:0] res, input logic [3:0] af,
                         input logic [3:0] cond, input logic [1:0] fw,
                         input logic rw, input logic [3:0] rd);
        Result    = res;
        ALUFlags  = af;
        Cond      = cond;
        FlagWrite = fw;
        RegWrite  = rw;
        Rd        = rd;
        in_valid  = 1'b1;
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic wait_accept();
        int   n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            #4;
            ok = in_ready;
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        chk("accept", ok, 1'b1);
    endtask

    task automatic send(input logic [31:0] res, input logic [3:0] af,
                        input logic [3:0] cond, input logic [1:0] fw,
                        input logic rw, input logic [3:0] rd);
        drive(res, af, cond, fw, rw, rd);
        wait_accept();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        Result    = '0;
        ALUFlags  = '0;
        Cond      = '0;
        FlagWrite = '0;
        RegWrite  = 1'b0;
        Rd        = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_result", out_result, 32'h0);
        chk("rst_rd", out_rd, 4'h0);
        chk("rst_we", out_we, 1'b0);
        chk("rst_condex", out_condex, 1'b0);
        chk("rst_flags", Flags, 4'h0);
        chk("rst_ready", in_ready, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1'b1);

        // ADD with AL
        send(32'h3FFF_FFFE, 4'b0000, 4'hE, 2'b11, 1'b1, 4'd3);
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_result", out_result, 32'h3FFF_FFFE);
        chk("t1_rd", out_rd, 4'd3);
        chk("t1_we", out_we, 1'b1);
        chk("t1_flags", Flags, 4'b0000);

        // AND sets N, then MI back-to-back sees it
        send(32'hFF0F_FFFF, 4'b1000, 4'hE, 2'b10, 1'b1, 4'd4);
        send(32'h0000_1234, 4'b0000, 4'h4, 2'b00, 1'b1, 4'd5);
        chk("t2_flags", Flags, 4'b1000);
        chk("t2_condex", out_condex, 1'b1);
        chk("t2_we", out_we, 1'b1);
        chk("t2_rd", out_rd, 4'd5);

        // Z set, then NE is squashed and cannot touch flags
        send(32'h0000_0000, 4'b0100, 4'hE, 2'b11, 1'b0, 4'd1);
        send(32'h0000_ABCD, 4'b1000, 4'h1, 2'b11, 1'b1, 4'd6);
        chk("t3_valid", out_valid, 1'b1);
        chk("t3_we", out_we, 1'b0);
        chk("t3_condex", out_condex, 1'b0);
        chk("t3_flags", Flags, 4'b0100);
        repeat (2) @(negedge clk);

        // Fill with downstream stalled, third op must wait
        out_ready = 1'b0;
        send(32'hFFFF_FFFF, 4'b1000, 4'hE, 2'b00, 1'b1, 4'd7);
        send(32'h0000_0001, 4'b0000, 4'hE, 2'b00, 1'b1, 4'd8);
        chk("t4_full_ready", in_ready, 1'b0);
        drive(32'h0000_0002, 4'b0000, 4'hE, 2'b00, 1'b1, 4'd9);
        repeat (3) begin
            @(negedge clk);
            chk("t4_hold_ready", in_ready, 1'b0);
            chk("t4_hold_valid", out_valid, 1'b1);
        end
        chk("t4_head_rd", out_rd, 4'd7);
        out_ready = 1'b1;
        wait_accept();
        repeat (4) @(negedge clk);

        // Steady push and pop at one entry
        for (int i = 0; i < 11; i++) begin
            if (i > 0) begin
                chk("t5_ready", in_ready, 1'b1);
                chk("t5_valid", out_valid, 1'b1);
            end
            send(32'(i) * 32'h1111_0001,
                 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 4'(i));
        end
        repeat (3) @(negedge clk);

        // Reset while full with a pending op
        out_ready = 1'b0;
        send(32'h0000_0001, 4'b1111, 4'hE, 2'b11, 1'b1, 4'd10);
        send(32'h0000_0002, 4'b0000, 4'hE, 2'b00, 1'b1, 4'd11);
        chk("t6_flags_before", Flags, 4'b1111);
        drive(32'h0000_0003, 4'b0000, 4'hE, 2'b11, 1'b1, 4'd12);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_valid", out_valid, 1'b0);
        chk("t6_flags", Flags, 4'b0000);
        chk("t6_ready_rst", in_ready, 1'b0);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_ready", in_ready, 1'b1);
        out_ready = 1'b1;

        // LS with C clear after reset passes
        send(32'h0000_0055, 4'b0110, 4'h9, 2'b11, 1'b1, 4'd12);
        chk("t7_we", out_we, 1'b1);
        repeat (3) @(negedge clk);
        chk("t7_flags", Flags, 4'b0110);
        chk("drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
